// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch/execute sequencer driving the PC register and
// the instruction-memory request.
// Optional build macro PC_FETCH_TRAP_EN adds a sticky TRAP state (trap_o)
// for misaligned jump/branch targets and sequential PC wrap.
module pc_fetch_ctrl #(
    parameter int unsigned instr_MEM_width = 256,
    parameter int unsigned PC_STEP         = 4,
    parameter int unsigned CNT_W           = 16,
    localparam int unsigned AW             = $clog2(instr_MEM_width)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [AW-1:0]    pc_i,
    output logic [AW-1:0]    pc_next_o,
    output logic             imem_req_o,
    output logic [AW-1:0]    imem_addr_o,
    input  logic             imem_ack_i,
    output logic             instr_valid_o,
    input  logic             exec_done_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic [AW-1:0]    branch_target_i,
    input  logic             jump_i,
    input  logic [AW-1:0]    jump_target_i,
    input  logic             halt_i,
`ifdef PC_FETCH_TRAP_EN
    output logic             trap_o,
`endif
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_HALT  = 3'd3
`ifdef PC_FETCH_TRAP_EN
        ,
        S_TRAP  = 3'd4
`endif
    } state_e;

    state_e           state_q, state_d;
    logic             imem_req_q;
    logic             instr_valid_q;
    logic             halted_q;
    logic [CNT_W-1:0] retired_q;
    logic             complete_c;
    logic [AW-1:0]    seq_pc_c;
    logic [AW-1:0]    target_c;
`ifdef PC_FETCH_TRAP_EN
    logic             trap_q;
    logic             bad_target_c;
`endif

    // The address is always the current PC; the PC register itself has no
    // enable, so pc_next_o defaults to a feedback of pc_i.
    assign imem_addr_o   = pc_i;
    assign imem_req_o    = imem_req_q;
    assign instr_valid_o = instr_valid_q;
    assign halted_o      = halted_q;
    assign retired_o     = retired_q;
`ifdef PC_FETCH_TRAP_EN
    assign trap_o        = trap_q;
`endif

    // Next-state and next-PC selection
    always_comb begin
        state_d    = state_q;
        pc_next_o  = pc_i;
        complete_c = 1'b0;
        seq_pc_c   = pc_i + AW'(PC_STEP);
        if (jump_i) begin
            target_c = jump_target_i;
        end else if (branch_i) begin
            target_c = branch_target_i;
        end else begin
            target_c = seq_pc_c;
        end
`ifdef PC_FETCH_TRAP_EN
        // Redirects must be step-aligned; a sequential step must not wrap.
        if (jump_i || branch_i) begin
            bad_target_c = (32'(target_c) % PC_STEP) != 32'd0;
        end else begin
            bad_target_c = seq_pc_c < pc_i;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Stall overrides done; halt wins over every redirect.
                if (exec_done_i && !stall_i) begin
                    complete_c = 1'b1;
                    if (halt_i) begin
                        state_d = S_HALT;
`ifdef PC_FETCH_TRAP_EN
                    end else if (bad_target_c) begin
                        state_d = S_TRAP;
`endif
                    end else begin
                        state_d   = S_FETCH;
                        pc_next_o = target_c;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
`ifdef PC_FETCH_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, registered status outputs and saturating retire counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            retired_q     <= '0;
`ifdef PC_FETCH_TRAP_EN
            trap_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            imem_req_q    <= (state_d == S_FETCH);
            instr_valid_q <= (state_d == S_EXEC);
`ifdef PC_FETCH_TRAP_EN
            halted_q      <= (state_d == S_HALT) || (state_d == S_TRAP);
            trap_q        <= (state_d == S_TRAP);
`else
            halted_q      <= (state_d == S_HALT);
`endif
            if (complete_c && (retired_q != {CNT_W{1'b1}})) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl with a local PC register.
// Build with PC_FETCH_TRAP_EN defined to exercise the trap variant.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, imem_ack_i, exec_done_i, stall_i;
    logic        branch_i, jump_i, halt_i;
    logic [7:0]  branch_target_i, jump_target_i;
    logic [7:0]  pc_q, pc_next_o, imem_addr_o;
    logic        imem_req_o, instr_valid_o, halted_o;
    logic [15:0] retired_o;
`ifdef PC_FETCH_TRAP_EN
    logic        trap_o;
`endif

    int total = 0;
    int bad   = 0;
    time t0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(
        .instr_MEM_width(256),
        .PC_STEP        (4),
        .CNT_W          (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .pc_i           (pc_q),
        .pc_next_o      (pc_next_o),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .instr_valid_o  (instr_valid_o),
        .exec_done_i    (exec_done_i),
        .stall_i        (stall_i),
        .branch_i       (branch_i),
        .branch_target_i(branch_target_i),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .halt_i         (halt_i),
`ifdef PC_FETCH_TRAP_EN
        .trap_o         (trap_o),
`endif
        .halted_o       (halted_o),
        .retired_o      (retired_o)
    );

    // PC register: no enable, async active-low reset to 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= 8'h00;
        else      pc_q <= pc_next_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        start_i = 1'b0; imem_ack_i = 1'b0; exec_done_i = 1'b0; stall_i = 1'b0;
        branch_i = 1'b0; jump_i = 1'b0; halt_i = 1'b0;
        branch_target_i = 8'h00; jump_target_i = 8'h00;
    endtask

    task automatic do_reset();
        clear_ctl();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic start_core();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // In FETCH: check request/address, ack immediately, land in EXEC
    task automatic fetch_ack(input logic [7:0] exp_addr);
        chk("fetch_req", 32'(imem_req_o), 32'd1);
        chk("fetch_addr", 32'(imem_addr_o), 32'(exp_addr));
        imem_ack_i = 1'b1;
        step();
        imem_ack_i = 1'b0;
        chk("exec_valid", 32'(instr_valid_o), 32'd1);
    endtask

    // In EXEC with control inputs preset: complete and check next PC
    task automatic exec_cmp(input string tag, input logic [7:0] exp_next);
        exec_done_i = 1'b1;
        #1;
        chk(tag, 32'(pc_next_o), 32'(exp_next));
        step();
        clear_ctl();
    endtask

    initial begin
        clear_ctl();
        rst = 1'b1;
        #2 rst = 1'b0;
        #10;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
        chk("rst_retired", 32'(retired_o), 32'd0);
        chk("rst_pc", 32'(pc_q), 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("idle_req", 32'(imem_req_o), 32'd0);

        // Back-to-back instructions, two cycles each
        start_core();
        t0 = $time;
        for (int i = 0; i < 3; i++) begin
            fetch_ack(8'(4 * i));
            exec_cmp("seq_next", 8'(4 * i + 4));
            chk("seq_pc", 32'(pc_q), 32'(4 * i + 4));
            chk("seq_retired", 32'(retired_o), 32'(i + 1));
        end
        chk("cpi_time", 32'($time - t0), 32'd60);

        // Delayed ack: request and address held for four cycles total
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", 32'(imem_req_o), 32'd1);
            chk("wait_addr", 32'(imem_addr_o), 32'h0C);
            step();
        end
        fetch_ack(8'h0C);
        stall_i = 1'b1;
        exec_done_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_next", 32'(pc_next_o), 32'h0C);
            step();
            chk("stall_pc", 32'(pc_q), 32'h0C);
            chk("stall_valid", 32'(instr_valid_o), 32'd1);
        end
        stall_i = 1'b0;
        exec_cmp("unstall_next", 8'h10);
        chk("unstall_pc", 32'(pc_q), 32'h10);
        chk("unstall_retired", 32'(retired_o), 32'd4);

        // Jump beats branch; then branch alone
        fetch_ack(8'h10);
        jump_i = 1'b1; jump_target_i = 8'h40;
        branch_i = 1'b1; branch_target_i = 8'h80;
        exec_cmp("jump_prio", 8'h40);
        chk("jump_pc", 32'(pc_q), 32'h40);
        fetch_ack(8'h40);
        branch_i = 1'b1; branch_target_i = 8'h10;
        exec_cmp("branch_next", 8'h10);
        chk("branch_retired", 32'(retired_o), 32'd6);

        // Halt at 0x10 is sticky and counted once
        fetch_ack(8'h10);
        halt_i = 1'b1; jump_i = 1'b1; jump_target_i = 8'h40;
        exec_cmp("halt_next", 8'h10);
        chk("halt_flag", 32'(halted_o), 32'd1);
        chk("halt_retired", 32'(retired_o), 32'd7);
        start_i = 1'b1; imem_ack_i = 1'b1; exec_done_i = 1'b1;
        branch_i = 1'b1; branch_target_i = 8'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_hold_pc", 32'(pc_q), 32'h10);
            chk("halt_hold_req", 32'(imem_req_o), 32'd0);
            chk("halt_hold_flag", 32'(halted_o), 32'd1);
        end
        chk("halt_hold_retired", 32'(retired_o), 32'd7);

        // Sequential step from the top of memory
        do_reset();
        start_core();
        fetch_ack(8'h00);
        jump_i = 1'b1; jump_target_i = 8'hFC;
        exec_cmp("to_fc", 8'hFC);
        fetch_ack(8'hFC);
`ifdef PC_FETCH_TRAP_EN
        exec_cmp("wrap_next", 8'hFC);
        chk("wrap_trap", 32'(trap_o), 32'd1);
        chk("wrap_halted", 32'(halted_o), 32'd1);
        chk("wrap_pc", 32'(pc_q), 32'hFC);
`else
        exec_cmp("wrap_next", 8'h00);
        chk("wrap_pc", 32'(pc_q), 32'h00);
        chk("wrap_halted", 32'(halted_o), 32'd0);
`endif
        chk("wrap_retired", 32'(retired_o), 32'd2);

        // Misaligned branch target
        do_reset();
        start_core();
        fetch_ack(8'h00);
        branch_i = 1'b1; branch_target_i = 8'h22;
`ifdef PC_FETCH_TRAP_EN
        exec_cmp("mis_next", 8'h00);
        chk("mis_trap", 32'(trap_o), 32'd1);
        chk("mis_pc", 32'(pc_q), 32'h00);
`else
        exec_cmp("mis_next", 8'h22);
        chk("mis_pc", 32'(pc_q), 32'h22);
`endif
        chk("mis_retired", 32'(retired_o), 32'd1);

        // Reset mid-fetch drops the request without a clock edge
        do_reset();
        start_core();
        chk("mid_req_before", 32'(imem_req_o), 32'd1);
        #3 rst = 1'b0;
        #1;
        chk("mid_req_async", 32'(imem_req_o), 32'd0);
        chk("mid_retired", 32'(retired_o), 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("mid_idle_req", 32'(imem_req_o), 32'd0);
        chk("mid_pc", 32'(pc_q), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
